// File: rtl/stopwatch_pkg.sv
// Shared definitions for the lap stopwatch: state encoding, BCD digit layout
// and the cascaded six-digit BCD increment/decrement/clamp helpers.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } sw_state_e;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  // Field offsets inside {m_hi,m_lo,s_hi,s_lo,c_hi,c_lo}
  localparam int C_LO = 0;
  localparam int C_HI = 4;
  localparam int S_LO = 8;
  localparam int S_HI = 12;
  localparam int M_LO = 16;
  localparam int M_HI = 20;
  localparam int DIGIT_OFS [6] = '{C_LO, C_HI, S_LO, S_HI, M_LO, M_HI};

  // flag = carry out of m_hi for increment, result-is-zero for decrement
  typedef struct packed {
    logic [23:0] value;
    logic        flag;
  } bcd6_res_t;

  function automatic logic [3:0] digit_limit(input int ofs);
    return (ofs == S_HI || ofs == M_HI) ? TENS_MAX : DIGIT_MAX;
  endfunction

  function automatic logic [23:0] bcd6_clamp(input logic [23:0] v);
    logic [23:0] r;
    logic [3:0]  lim;
    r = v;
    for (int i = 0; i < 6; i++) begin
      lim = digit_limit(DIGIT_OFS[i]);
      if (v[DIGIT_OFS[i] +: 4] > lim) r[DIGIT_OFS[i] +: 4] = lim;
    end
    return r;
  endfunction

  function automatic bcd6_res_t bcd6_inc(input logic [23:0] v);
    bcd6_res_t r;
    logic      carry;
    logic [3:0] d;
    r.value = v;
    carry   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = v[DIGIT_OFS[i] +: 4];
      if (carry) begin
        if (d >= digit_limit(DIGIT_OFS[i])) begin
          d = 4'd0;
        end else begin
          d     = d + 4'd1;
          carry = 1'b0;
        end
      end
      r.value[DIGIT_OFS[i] +: 4] = d;
    end
    r.flag = carry;
    return r;
  endfunction

  function automatic bcd6_res_t bcd6_dec(input logic [23:0] v);
    bcd6_res_t r;
    logic      borrow;
    logic [3:0] d;
    r.value = v;
    borrow  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = v[DIGIT_OFS[i] +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          d = digit_limit(DIGIT_OFS[i]);
        end else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end
      r.value[DIGIT_OFS[i] +: 4] = d;
    end
    r.flag = (r.value == 24'd0);
    return r;
  endfunction

endpackage

// File: rtl/key_press.sv
// Raw active-low key -> 2-flop synchroniser -> debounce -> one-cycle pulse
// on an accepted press. Releases are debounced but never pulse.
module key_press #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic press_o
);

  localparam int              CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;

  // Idle level of an active-low key is 1, so the pipeline resets high and a
  // key held down through reset is not reported as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      sync_q  <= {sync_q[0], key_n_i};
      press_q <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
        press_q  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/lap_stopwatch.sv
// BCD stopwatch/countdown with start/pause, clear, lap capture with split
// hold, and lap recall while paused or done.
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 100,
  parameter int DEB_CYCLES = 500_000,
  parameter int LAP_DEPTH  = 8,
  parameter int HOLD_TICKS = 200
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_start_pause,
  input  logic                         key_lap,
  input  logic                         key_clear,
  input  logic                         mode_down,
  input  logic [23:0]                  preset_bcd,
  output logic [23:0]                  disp_bcd,
  output logic                         running,
  output logic                         showing_lap,
  output logic [$clog2(LAP_DEPTH)-1:0] view_idx,
  output logic [$clog2(LAP_DEPTH):0]   lap_count,
  output logic                         lap_full,
  output logic                         expired,
  output logic                         wrap
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int IW  = $clog2(LAP_DEPTH);
  localparam int CW  = IW + 1;
  localparam int HW  = $clog2(HOLD_TICKS + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [CW-1:0] LAP_FULL  = CW'(LAP_DEPTH);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  logic clr_p, ss_p, lap_p;

  key_press #(.DEB_CYCLES(DEB_CYCLES)) u_key_clear (
    .clk(clk), .rst(rst), .key_n_i(key_clear),       .press_o(clr_p));
  key_press #(.DEB_CYCLES(DEB_CYCLES)) u_key_start (
    .clk(clk), .rst(rst), .key_n_i(key_start_pause), .press_o(ss_p));
  key_press #(.DEB_CYCLES(DEB_CYCLES)) u_key_lap (
    .clk(clk), .rst(rst), .key_n_i(key_lap),         .press_o(lap_p));

  sw_state_e     state_q;
  logic [23:0]   time_q;
  logic          dir_q;
  logic [PW-1:0] pre_q;
  logic [CW-1:0] lap_cnt_q;
  logic [IW-1:0] view_q;
  logic          showing_q;
  logic          hold_q;
  logic [HW-1:0] hold_cnt_q;
  logic [23:0]   split_q;
  logic          expired_q;
  logic          wrap_q;
  logic [23:0]   disp_q;
  logic [23:0]   lap_mem [LAP_DEPTH];

  logic          do_clear, do_start, do_lap;
  logic          tick, time_zero, done_hit, full, lap_wr, view_wrap;
  logic [CW-1:0] view_inc;
  bcd6_res_t     inc_r, dec_r;
  logic [23:0]   disp_d;

  // Clear beats start_pause beats lap when pulses coincide.
  assign do_clear = clr_p;
  assign do_start = ss_p & ~clr_p;
  assign do_lap   = lap_p & ~clr_p & ~ss_p;

  assign tick      = (state_q == ST_RUN) && (pre_q == PRE_LAST);
  assign time_zero = (time_q == 24'd0);
  assign full      = (lap_cnt_q == LAP_FULL);
  assign lap_wr    = do_lap && (state_q == ST_RUN) && !full;
  assign view_inc  = {1'b0, view_q} + CW'(1);
  assign view_wrap = (view_inc == lap_cnt_q);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    inc_r    = bcd6_inc(time_q);
    dec_r    = bcd6_dec(time_q);
    done_hit = tick && dir_q && (time_zero || dec_r.flag);
    disp_d   = time_q;
    if (showing_q)   disp_d = lap_mem[view_q];
    else if (hold_q) disp_d = split_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      time_q     <= '0;
      dir_q      <= 1'b0;
      pre_q      <= '0;
      lap_cnt_q  <= '0;
      view_q     <= '0;
      showing_q  <= 1'b0;
      hold_q     <= 1'b0;
      hold_cnt_q <= '0;
      split_q    <= '0;
      expired_q  <= 1'b0;
      wrap_q     <= 1'b0;
      disp_q     <= '0;
    end else begin
      wrap_q <= 1'b0;
      disp_q <= disp_d;
      if (do_clear) begin
        state_q    <= ST_IDLE;
        time_q     <= mode_down ? bcd6_clamp(preset_bcd) : 24'd0;
        dir_q      <= mode_down;
        pre_q      <= '0;
        lap_cnt_q  <= '0;
        view_q     <= '0;
        showing_q  <= 1'b0;
        hold_q     <= 1'b0;
        hold_cnt_q <= '0;
        expired_q  <= 1'b0;
      end else begin
        if (tick) begin
          pre_q <= '0;
          if (done_hit) begin
            // A zero preset enters DONE without wrapping to 59:59.99.
            state_q   <= ST_DONE;
            expired_q <= 1'b1;
            if (!time_zero) time_q <= dec_r.value;
          end else if (dir_q) begin
            time_q <= dec_r.value;
          end else begin
            time_q <= inc_r.value;
            wrap_q <= inc_r.flag;
          end
          if (hold_q) begin
            if (hold_cnt_q == HOLD_LAST) hold_q <= 1'b0;
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end else if (state_q == ST_RUN) begin
          pre_q <= pre_q + PW'(1);
        end

        if (do_start) begin
          showing_q <= 1'b0;
          unique case (state_q)
            ST_IDLE: begin
              state_q <= ST_RUN;
              pre_q   <= '0;
            end
            ST_RUN:   if (!done_hit) state_q <= ST_PAUSE;
            ST_PAUSE: state_q <= ST_RUN;
            ST_DONE:  ;
          endcase
        end

        if (do_lap) begin
          if (state_q == ST_RUN) begin
            split_q    <= time_q;
            hold_q     <= 1'b1;
            hold_cnt_q <= '0;
            if (!full) lap_cnt_q <= lap_cnt_q + CW'(1);
          end else if ((state_q == ST_PAUSE || state_q == ST_DONE) && lap_cnt_q != '0) begin
            showing_q <= 1'b1;
            view_q    <= (!showing_q || view_wrap) ? '0 : view_inc[IW-1:0];
          end
        end
      end
    end
  end

  // NOTE: the lap buffer has no reset; lap_count gates every read, so stale
  // contents are never displayed and the array stays a plain register file.
  always_ff @(posedge clk) begin
    if (lap_wr) lap_mem[lap_cnt_q[IW-1:0]] <= time_q;
  end

  assign disp_bcd    = disp_q;
  assign running     = (state_q == ST_RUN);
  assign showing_lap = showing_q;
  assign view_idx    = view_q;
  assign lap_count   = lap_cnt_q;
  assign lap_full    = full;
  assign expired     = expired_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch with small clock/debounce parameters:
// DIV=10, 4-cycle debounce, 4 laps, 3-tick split hold.
module tb_lap_stopwatch;

  logic        clk;
  logic        rst;
  logic        key_ss, key_lap, key_clr;
  logic        mode_down;
  logic [23:0] preset_bcd;
  logic [23:0] disp_bcd;
  logic        running, showing_lap, lap_full, expired, wrap;
  logic [1:0]  view_idx;
  logic [2:0]  lap_count;

  int checks   = 0;
  int failures = 0;

  localparam int K_SS  = 0;
  localparam int K_LAP = 1;
  localparam int K_CLR = 2;

  lap_stopwatch #(
    .CLK_HZ(1000), .TICK_HZ(100), .DEB_CYCLES(4), .LAP_DEPTH(4), .HOLD_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst),
    .key_start_pause(key_ss), .key_lap(key_lap), .key_clear(key_clr),
    .mode_down(mode_down), .preset_bcd(preset_bcd),
    .disp_bcd(disp_bcd), .running(running), .showing_lap(showing_lap),
    .view_idx(view_idx), .lap_count(lap_count), .lap_full(lap_full),
    .expired(expired), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      K_SS:    key_ss  = v;
      K_LAP:   key_lap = v;
      default: key_clr = v;
    endcase
  endtask

  // Press at position 0 takes effect on edge 7, display on edge 8; returns at 16.
  task automatic tap(input int k);
    set_key(k, 1'b0);
    cycles(8);
    set_key(k, 1'b1);
    cycles(8);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycles(3);
    checks++;
    if ({disp_bcd, running, showing_lap, view_idx, lap_count, lap_full, expired, wrap} !== 34'd0) begin
      $display("FAIL reset_outputs got=%h exp=0",
               {disp_bcd, running, showing_lap, view_idx, lap_count, lap_full, expired, wrap});
      failures++;
    end
    rst = 1'b0;
    cycles(2);
    checks++;
    if (disp_bcd !== 24'h000000 || running !== 1'b0) begin
      $display("FAIL after_reset got disp=%h run=%b exp disp=000000 run=0", disp_bcd, running);
      failures++;
    end
  endtask

  task automatic test_run_pause();
    tap(K_SS);
    cycles(12348 - 16);
    checks++;
    if (disp_bcd !== 24'h001234 || running !== 1'b1) begin
      $display("FAIL run_1234 got disp=%h run=%b exp disp=001234 run=1", disp_bcd, running);
      failures++;
    end
    tap(K_SS);
    cycles(500);
    checks++;
    if (disp_bcd !== 24'h001234 || running !== 1'b0) begin
      $display("FAIL pause_hold got disp=%h run=%b exp disp=001234 run=0", disp_bcd, running);
      failures++;
    end
    // Paused with the prescaler at 8: the tick lands two edges after resume.
    set_key(K_SS, 1'b0);
    cycles(8);
    checks++;
    if (disp_bcd !== 24'h001234) begin
      $display("FAIL resume_early got=%h exp=001234", disp_bcd);
      failures++;
    end
    set_key(K_SS, 1'b1);
    cycles(2);
    checks++;
    if (disp_bcd !== 24'h001235 || running !== 1'b1) begin
      $display("FAIL resume_fraction got disp=%h run=%b exp disp=001235 run=1", disp_bcd, running);
      failures++;
    end
    cycles(8);
    tap(K_CLR);
    checks++;
    if (disp_bcd !== 24'h000000 || running !== 1'b0) begin
      $display("FAIL clear_run got disp=%h run=%b exp disp=000000 run=0", disp_bcd, running);
      failures++;
    end
  endtask

  task automatic test_wrap();
    force dut.time_q = 24'h595998;
    cycles(1);
    release dut.time_q;
    cycles(2);
    checks++;
    if (disp_bcd !== 24'h595998) begin
      $display("FAIL preload got=%h exp=595998", disp_bcd);
      failures++;
    end
    set_key(K_SS, 1'b0);
    cycles(8);
    set_key(K_SS, 1'b1);
    cycles(10);
    checks++;
    if (disp_bcd !== 24'h595999 || wrap !== 1'b0) begin
      $display("FAIL wrap_tick1 got disp=%h wrap=%b exp disp=595999 wrap=0", disp_bcd, wrap);
      failures++;
    end
    cycles(9);
    checks++;
    if (wrap !== 1'b1) begin
      $display("FAIL wrap_pulse got=%b exp=1", wrap);
      failures++;
    end
    cycles(1);
    checks++;
    if (wrap !== 1'b0 || disp_bcd !== 24'h000000 || running !== 1'b1) begin
      $display("FAIL wrap_after got wrap=%b disp=%h run=%b exp wrap=0 disp=000000 run=1",
               wrap, disp_bcd, running);
      failures++;
    end
    cycles(8);
    tap(K_CLR);
  endtask

  task automatic test_countdown();
    mode_down  = 1'b1;
    preset_bcd = 24'h000005;
    tap(K_CLR);
    checks++;
    if (disp_bcd !== 24'h000005 || expired !== 1'b0) begin
      $display("FAIL down_load got disp=%h exp_flag=%b exp disp=000005 flag=0", disp_bcd, expired);
      failures++;
    end
    tap(K_SS);
    cycles(40);
    checks++;
    if (disp_bcd !== 24'h000001 || expired !== 1'b0 || running !== 1'b1) begin
      $display("FAIL down_4ticks got disp=%h flag=%b run=%b exp disp=000001 flag=0 run=1",
               disp_bcd, expired, running);
      failures++;
    end
    cycles(1);
    checks++;
    if (expired !== 1'b1 || running !== 1'b0) begin
      $display("FAIL down_done got flag=%b run=%b exp flag=1 run=0", expired, running);
      failures++;
    end
    cycles(1);
    checks++;
    if (disp_bcd !== 24'h000000) begin
      $display("FAIL down_zero got=%h exp=000000", disp_bcd);
      failures++;
    end
    tap(K_SS);
    cycles(20);
    checks++;
    if (running !== 1'b0 || expired !== 1'b1 || disp_bcd !== 24'h000000) begin
      $display("FAIL done_start_ignored got run=%b flag=%b disp=%h exp run=0 flag=1 disp=000000",
               running, expired, disp_bcd);
      failures++;
    end
    tap(K_CLR);
    checks++;
    if (disp_bcd !== 24'h000005 || expired !== 1'b0) begin
      $display("FAIL down_reclear got disp=%h flag=%b exp disp=000005 flag=0", disp_bcd, expired);
      failures++;
    end
    preset_bcd = 24'hABCDEF;
    tap(K_CLR);
    checks++;
    if (disp_bcd !== 24'h595999) begin
      $display("FAIL preset_clamp got=%h exp=595999", disp_bcd);
      failures++;
    end
    preset_bcd = 24'h000000;
    tap(K_CLR);
    tap(K_SS);
    checks++;
    if (running !== 1'b1 || expired !== 1'b0) begin
      $display("FAIL zero_preset_run got run=%b flag=%b exp run=1 flag=0", running, expired);
      failures++;
    end
    cycles(1);
    checks++;
    if (running !== 1'b0 || expired !== 1'b1) begin
      $display("FAIL zero_preset_done got run=%b flag=%b exp run=0 flag=1", running, expired);
      failures++;
    end
    cycles(1);
    checks++;
    if (disp_bcd !== 24'h000000) begin
      $display("FAIL zero_preset_nodec got=%h exp=000000", disp_bcd);
      failures++;
    end
    mode_down = 1'b0;
    tap(K_CLR);
    checks++;
    if (disp_bcd !== 24'h000000 || expired !== 1'b0) begin
      $display("FAIL up_clear got disp=%h flag=%b exp disp=000000 flag=0", disp_bcd, expired);
      failures++;
    end
  endtask

  task automatic test_laps();
    logic [23:0] split;
    logic [23:0] shown;
    tap(K_SS);
    cycles(987);
    for (int i = 1; i <= 5; i++) begin
      split = 24'(i) << 8;
      set_key(K_LAP, 1'b0);
      cycles(8);
      set_key(K_LAP, 1'b1);
      cycles(25);
      checks++;
      if (disp_bcd !== split) begin
        $display("FAIL lap%0d_hold got=%h exp=%h", i, disp_bcd, split);
        failures++;
      end
      checks++;
      if (lap_count !== 3'((i > 4) ? 4 : i)) begin
        $display("FAIL lap%0d_count got=%0d exp=%0d", i, lap_count, (i > 4) ? 4 : i);
        failures++;
      end
      cycles(2);
      checks++;
      if (disp_bcd !== (split | 24'h000003)) begin
        $display("FAIL lap%0d_live got=%h exp=%h", i, disp_bcd, split | 24'h000003);
        failures++;
      end
      if (i < 5) cycles(965);
    end
    checks++;
    if (lap_full !== 1'b1) begin
      $display("FAIL lap_full got=%b exp=1", lap_full);
      failures++;
    end
    tap(K_SS);
    for (int j = 0; j < 5; j++) begin
      shown = 24'((j % 4) + 1) << 8;
      tap(K_LAP);
      checks++;
      if (showing_lap !== 1'b1 || view_idx !== 2'(j % 4) || disp_bcd !== shown) begin
        $display("FAIL view%0d got show=%b idx=%0d disp=%h exp show=1 idx=%0d disp=%h",
                 j, showing_lap, view_idx, disp_bcd, j % 4, shown);
        failures++;
      end
    end
    tap(K_SS);
    checks++;
    if (showing_lap !== 1'b0 || disp_bcd !== 24'h000504 || running !== 1'b1) begin
      $display("FAIL view_exit got show=%b disp=%h run=%b exp show=0 disp=000504 run=1",
               showing_lap, disp_bcd, running);
      failures++;
    end
  endtask

  task automatic test_priority_glitch();
    key_clr = 1'b0;
    key_ss  = 1'b0;
    cycles(8);
    key_clr = 1'b1;
    key_ss  = 1'b1;
    cycles(8);
    checks++;
    if (running !== 1'b0 || disp_bcd !== 24'h000000 || lap_count !== 3'd0) begin
      $display("FAIL clear_priority got run=%b disp=%h laps=%0d exp run=0 disp=000000 laps=0",
               running, disp_bcd, lap_count);
      failures++;
    end
    key_ss = 1'b0;
    cycles(3);
    key_ss = 1'b1;
    cycles(12);
    checks++;
    if (running !== 1'b0) begin
      $display("FAIL glitch_reject got run=%b exp=0", running);
      failures++;
    end
    key_ss = 1'b0;
    cycles(6);
    checks++;
    if (running !== 1'b0) begin
      $display("FAIL key_latency_early got run=%b exp=0", running);
      failures++;
    end
    cycles(1);
    checks++;
    if (running !== 1'b1) begin
      $display("FAIL key_latency got run=%b exp=1", running);
      failures++;
    end
    key_ss = 1'b1;
    cycles(10);
  endtask

  task automatic test_rst_mid_run();
    tap(K_LAP);
    cycles(30);
    tap(K_LAP);
    checks++;
    if (lap_count !== 3'd2) begin
      $display("FAIL pre_rst_laps got=%0d exp=2", lap_count);
      failures++;
    end
    rst = 1'b1;
    cycles(1);
    checks++;
    if ({disp_bcd, running, showing_lap, view_idx, lap_count, lap_full, expired, wrap} !== 34'd0) begin
      $display("FAIL rst_mid_run got=%h exp=0",
               {disp_bcd, running, showing_lap, view_idx, lap_count, lap_full, expired, wrap});
      failures++;
    end
    rst = 1'b0;
    tap(K_SS);
    checks++;
    if (disp_bcd !== 24'h000000 || running !== 1'b1) begin
      $display("FAIL restart got disp=%h run=%b exp disp=000000 run=1", disp_bcd, running);
      failures++;
    end
    cycles(2);
    checks++;
    if (disp_bcd !== 24'h000001) begin
      $display("FAIL restart_tick got=%h exp=000001", disp_bcd);
      failures++;
    end
  endtask

  initial begin
    rst        = 1'b1;
    key_ss     = 1'b1;
    key_lap    = 1'b1;
    key_clr    = 1'b1;
    mode_down  = 1'b0;
    preset_bcd = 24'h000000;
    test_reset();
    test_run_pause();
    test_wrap();
    test_countdown();
    test_laps();
    test_priority_glitch();
    test_rst_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
